// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the IF/MEM unified memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEF       = 32;
    localparam int unsigned DW_DEF       = 32;
    localparam int unsigned MAX_DWIN_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of back-to-back data grants; flags when fetch must win.
// Only present when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_ctr #(
    parameter int MAX_DWIN = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic data_grant,
    input  logic fetch_grant,
    output logic limit_hit
);
    localparam int CW = $clog2(MAX_DWIN + 1);

    logic [CW-1:0] cnt_r;

    // Count data grants since the last fetch grant, holding at the limit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (fetch_grant) begin
            cnt_r <= '0;
        end else if (data_grant && (cnt_r != CW'(MAX_DWIN))) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Threshold compare.
    always_comb begin
        limit_hit = (cnt_r >= CW'(MAX_DWIN));
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after MAX_DWIN data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_DWIN = MAX_DWIN_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ireq,
    input  logic [AW-1:0]   iaddr,
    input  logic            iflush,
    output logic [DW-1:0]   irdata,
    output logic            ivalid,
    output logic            istall,
    input  logic            dreq,
    input  logic            dwe,
    input  logic [AW-1:0]   daddr,
    input  logic [DW-1:0]   dwdata,
    input  logic [DW/8-1:0] dbe,
    output logic [DW-1:0]   drdata,
    output logic            dvalid,
    output logic            dstall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata
);

    arb_state_e state_r;
    arb_state_e next_state_s;
    arb_owner_e owner_r;
    logic       kill_r;
    logic       grant_i_s;
    logic       grant_d_s;
    logic       force_i_s;

    if (MAX_DWIN < 1) begin : g_dwin_chk
        $error("MAX_DWIN must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    logic starve_hit_s;

    arb_starve_ctr #(
        .MAX_DWIN (MAX_DWIN)
    ) u_starve_ctr (
        .clk         (clk),
        .rstn        (rstn),
        .data_grant  (grant_d_s),
        .fetch_grant (grant_i_s),
        .limit_hit   (starve_hit_s)
    );

    // Fetch overrides data priority once the data window is exhausted.
    always_comb begin
        force_i_s = starve_hit_s && ireq && !iflush;
    end
`else
    // Strict data priority.
    always_comb begin
        force_i_s = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and grant decode; data is the older instruction so it wins.
    always_comb begin
        next_state_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (force_i_s) begin
                    grant_i_s    = 1'b1;
                    next_state_s = IBUSY;
                end else if (dreq) begin
                    grant_d_s    = 1'b1;
                    next_state_s = DBUSY;
                end else if (ireq && !iflush) begin
                    grant_i_s    = 1'b1;
                    next_state_s = IBUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ready) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = state_r;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Stall outputs follow the request and the registered completion pulse.
    always_comb begin
        istall = ireq && !ivalid;
        dstall = dreq && !dvalid;
    end

    // Memory-side transaction registers and response capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            irdata    <= '0;
            drdata    <= '0;
            ivalid    <= 1'b0;
            dvalid    <= 1'b0;
            owner_r   <= OWN_I;
            kill_r    <= 1'b0;
        end else begin
            ivalid <= 1'b0;
            dvalid <= 1'b0;
            case (state_r)
                IDLE: begin
                    kill_r <= 1'b0;
                    if (grant_d_s) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dwe;
                        mem_addr  <= daddr;
                        mem_wdata <= dwdata;
                        mem_be    <= dbe;
                        owner_r   <= OWN_D;
                    end else if (grant_i_s) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= iaddr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                        owner_r   <= OWN_I;
                    end else begin
                        mem_req <= 1'b0;
                    end
                end
                IBUSY, DBUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (owner_r == OWN_D) begin
                            drdata <= mem_we ? '0 : mem_rdata;
                            dvalid <= 1'b1;
                        end else if (!(kill_r || iflush)) begin
                            irdata <= mem_rdata;
                            ivalid <= 1'b1;
                        end else begin
                            irdata <= irdata;
                        end
                    end else if ((owner_r == OWN_I) && iflush) begin
                        // A redirect kills the fetch but the memory access still runs out.
                        kill_r <= 1'b1;
                    end else begin
                        kill_r <= kill_r;
                    end
                end
                RESP:    mem_req <= 1'b0;
                default: mem_req <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default and ARB_STARVE_GUARD_EN builds).
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          iflush;
    logic [DW-1:0] irdata;
    logic          ivalid;
    logic          istall;
    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic [3:0]    dbe;
    logic [DW-1:0] drdata;
    logic          dvalid;
    logic          dstall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    int n_checks;
    int n_fail;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DWIN(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ireq      (ireq),
        .iaddr     (iaddr),
        .iflush    (iflush),
        .irdata    (irdata),
        .ivalid    (ivalid),
        .istall    (istall),
        .dreq      (dreq),
        .dwe       (dwe),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dbe       (dbe),
        .drdata    (drdata),
        .dvalid    (dvalid),
        .dstall    (dstall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] exp_addr [6];
        n_checks  = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        ireq      = 1'b0;
        iaddr     = 32'h0;
        iflush    = 1'b0;
        dreq      = 1'b0;
        dwe       = 1'b0;
        daddr     = 32'h0;
        dwdata    = 32'h0;
        dbe       = 4'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        check_eq("rst_mem_req", 64'(mem_req), 64'h0);
        check_eq("rst_mem_we", 64'(mem_we), 64'h0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'h0);
        check_eq("rst_mem_be", 64'(mem_be), 64'h0);
        check_eq("rst_irdata", 64'(irdata), 64'h0);
        check_eq("rst_drdata", 64'(drdata), 64'h0);
        check_eq("rst_ivalid", 64'(ivalid), 64'h0);
        check_eq("rst_dvalid", 64'(dvalid), 64'h0);
        rstn = 1'b1;
        tick();

        // 1: reset while a load waits on memory
        dreq  = 1'b1;
        daddr = 32'h0000_0200;
        tick();
        check_eq("t1_grant_req", 64'(mem_req), 64'h1);
        check_eq("t1_grant_addr", 64'(mem_addr), 64'h200);
        check_eq("t1_dstall", 64'(dstall), 64'h1);
        rstn = 1'b0;
        tick();
        check_eq("t1_rst_req", 64'(mem_req), 64'h0);
        check_eq("t1_rst_addr", 64'(mem_addr), 64'h0);
        rstn      = 1'b1;
        dreq      = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t1_no_dvalid", 64'(dvalid), 64'h0);
            check_eq("t1_idle_req", 64'(mem_req), 64'h0);
        end
        mem_ready = 1'b0;

        // 2: single fetch, zero wait states
        ireq  = 1'b1;
        iaddr = 32'h0000_0004;
        tick();
        check_eq("t2_req", 64'(mem_req), 64'h1);
        check_eq("t2_addr", 64'(mem_addr), 64'h4);
        check_eq("t2_we", 64'(mem_we), 64'h0);
        check_eq("t2_be", 64'(mem_be), 64'hF);
        check_eq("t2_istall", 64'(istall), 64'h1);
        check_eq("t2_ivalid_early", 64'(ivalid), 64'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        tick();
        check_eq("t2_ivalid", 64'(ivalid), 64'h1);
        check_eq("t2_irdata", 64'(irdata), 64'h0050_0093);
        check_eq("t2_istall_low", 64'(istall), 64'h0);
        check_eq("t2_req_drop", 64'(mem_req), 64'h0);
        mem_ready = 1'b0;
        ireq      = 1'b0;
        tick();
        check_eq("t2_ivalid_pulse", 64'(ivalid), 64'h0);

        // 3: contention, data write first then fetch
        ireq   = 1'b1;
        iaddr  = 32'h0000_0008;
        dreq   = 1'b1;
        dwe    = 1'b1;
        daddr  = 32'h0000_0100;
        dwdata = 32'hDEAD_BEEF;
        dbe    = 4'b1111;
        tick();
        check_eq("t3_we", 64'(mem_we), 64'h1);
        check_eq("t3_addr", 64'(mem_addr), 64'h100);
        check_eq("t3_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check_eq("t3_istall", 64'(istall), 64'h1);
        tick();
        check_eq("t3_we_hold", 64'(mem_we), 64'h1);
        check_eq("t3_istall_hold", 64'(istall), 64'h1);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        check_eq("t3_dvalid", 64'(dvalid), 64'h1);
        check_eq("t3_drdata_wr", 64'(drdata), 64'h0);
        check_eq("t3_istall_resp", 64'(istall), 64'h1);
        check_eq("t3_ivalid_none", 64'(ivalid), 64'h0);
        mem_ready = 1'b0;
        dreq      = 1'b0;
        dwe       = 1'b0;
        tick();
        check_eq("t3_resp_idle_req", 64'(mem_req), 64'h0);
        tick();
        check_eq("t3_fetch_req", 64'(mem_req), 64'h1);
        check_eq("t3_fetch_addr", 64'(mem_addr), 64'h8);
        check_eq("t3_fetch_we", 64'(mem_we), 64'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_000A;
        tick();
        check_eq("t3_ivalid", 64'(ivalid), 64'h1);
        check_eq("t3_irdata", 64'(irdata), 64'hA);
        ireq      = 1'b0;
        mem_ready = 1'b0;
        tick();

        // 4: load with three wait states
        dreq      = 1'b1;
        daddr     = 32'h0000_0300;
        mem_rdata = 32'hFFFF_0000;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_req_stable", 64'(mem_req), 64'h1);
            check_eq("t4_addr_stable", 64'(mem_addr), 64'h300);
            check_eq("t4_no_dvalid", 64'(dvalid), 64'h0);
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        check_eq("t4_dvalid", 64'(dvalid), 64'h1);
        check_eq("t4_drdata", 64'(drdata), 64'hCAFE_F00D);
        dreq      = 1'b0;
        mem_ready = 1'b0;
        tick();

        // 5: flush during IBUSY, then redirect fetch
        ireq  = 1'b1;
        iaddr = 32'h0000_0020;
        tick();
        check_eq("t5_req", 64'(mem_req), 64'h1);
        iflush = 1'b1;
        tick();
        iflush    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        tick();
        check_eq("t5_no_ivalid", 64'(ivalid), 64'h0);
        check_eq("t5_irdata_kept", 64'(irdata), 64'hA);
        check_eq("t5_req_drop", 64'(mem_req), 64'h0);
        mem_ready = 1'b0;
        iaddr     = 32'h0000_0040;
        tick();
        check_eq("t5_resp_no_req", 64'(mem_req), 64'h0);
        tick();
        check_eq("t5_redirect_req", 64'(mem_req), 64'h1);
        check_eq("t5_redirect_addr", 64'(mem_addr), 64'h40);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0013;
        tick();
        check_eq("t5_ivalid", 64'(ivalid), 64'h1);
        check_eq("t5_irdata", 64'(irdata), 64'h13);
        mem_ready = 1'b0;
        ireq      = 1'b0;
        tick();
        // flush in IDLE blocks the fetch grant
        ireq   = 1'b1;
        iflush = 1'b1;
        tick();
        check_eq("t5_idle_flush_block", 64'(mem_req), 64'h0);
        ireq   = 1'b0;
        iflush = 1'b0;
        tick();

        // 6: data held high against a pending fetch
`ifdef ARB_STARVE_GUARD_EN
        exp_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h80, 32'h400};
`else
        exp_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h400, 32'h400};
`endif
        dreq      = 1'b1;
        dwe       = 1'b0;
        daddr     = 32'h0000_0400;
        ireq      = 1'b1;
        iaddr     = 32'h0000_0080;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_7777;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("t6_grant_addr", 64'(mem_addr), 64'(exp_addr[k]));
            tick();
            check_eq("t6_ivalid", 64'(ivalid), 64'(exp_addr[k] == 32'h80));
            check_eq("t6_dvalid", 64'(dvalid), 64'(exp_addr[k] == 32'h400));
            tick();
        end
        dreq      = 1'b0;
        ireq      = 1'b0;
        mem_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
